// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths, constants and requester ids
package rf_pkg;

  localparam int XLEN    = 32;
  localparam int RF_AW   = 5;
  localparam int RF_NREG = 32;
  localparam logic [RF_AW-1:0] RF_ZERO = '0;

  typedef enum logic {
    REQ_EXEC = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write bit per architectural register
// Set on allocation, cleared on regfile commit; set wins a same-edge collision.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW   = RF_AW,
  parameter int NREG = RF_NREG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_rd] = 1'b0;
    end
    if (set_en && (set_rd != '0)) begin
      pending_d[set_rd] = 1'b1;
    end
    // x0 is hard-wired zero and can never be pending
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign busy1 = (ra1 != '0) && pending_q[ra1];
  assign busy2 = (ra2 != '0) && pending_q[ra2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin writeback arbiter for the single regfile write port
// Registered write stage plus pending-write scoreboard for decode RAW stalls.
module rf_wb_arbiter #(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW   = rf_pkg::RF_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic            busy1,
  output logic            busy2,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [AW-1:0]   req0_wa,
  input  logic [XLEN-1:0] req0_wd,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [AW-1:0]   req1_wa,
  input  logic [XLEN-1:0] req1_wd,
  output logic            rf_write,
  output logic [AW-1:0]   rf_wa,
  output logic [XLEN-1:0] rf_wd
);

  import rf_pkg::*;

  req_id_e         rr_last_q;
  req_id_e         rr_last_d;
  logic            rf_write_q;
  logic            rf_write_d;
  logic [AW-1:0]   rf_wa_q;
  logic [AW-1:0]   rf_wa_d;
  logic [XLEN-1:0] rf_wd_q;
  logic [XLEN-1:0] rf_wd_d;

  logic            grant0;
  logic            grant1;
  logic [AW-1:0]   win_wa;
  logic [XLEN-1:0] win_wd;

  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    rr_last_d  = rr_last_q;
    rf_write_d = 1'b0;
    rf_wa_d    = rf_wa_q;
    rf_wd_d    = rf_wd_q;

    // Requesters must never see a grant while the block is held in reset
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        if (rr_last_q == REQ_LOAD) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end

    win_wa = grant1 ? req1_wa : req0_wa;
    win_wd = grant1 ? req1_wd : req0_wd;

    if (grant0) begin
      rr_last_d = REQ_EXEC;
    end else if (grant1) begin
      rr_last_d = REQ_LOAD;
    end

    // x0 writes are consumed here so the regfile never sees them
    if ((grant0 || grant1) && (win_wa != '0)) begin
      rf_write_d = 1'b1;
      rf_wa_d    = win_wa;
      rf_wd_d    = win_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= REQ_LOAD;
      rf_write_q <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      rf_write_q <= rf_write_d;
      rf_wa_q    <= rf_wa_d;
      rf_wd_q    <= rf_wd_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rf_write   = rf_write_q;
  assign rf_wa      = rf_wa_q;
  assign rf_wd      = rf_wd_q;

  rf_scoreboard #(
    .AW   (AW),
    .NREG (1 << AW)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (alloc_valid),
    .set_rd (alloc_rd),
    .clr_en (rf_write_q),
    .clr_rd (rf_wa_q),
    .ra1    (ra1),
    .ra2    (ra2),
    .busy1  (busy1),
    .busy2  (busy2)
  );

endmodule
